// File: rtl/clk_freq_divider_pkg.sv
// ============================================================================
// Module      : clk_freq_divider_pkg
// Description : Shared constants for the programmable clock divider.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package clk_freq_divider_pkg;

    localparam int C_DEFAULT_WIDTH = 4;

endpackage : clk_freq_divider_pkg

`default_nettype wire

// File: rtl/clk_freq_divider.sv
// ============================================================================
// Module      : clk_freq_divider
// Description : Runtime-programmable divider; clk_out toggles every div clocks
//               (period 2*div, 50% duty). div=0 halts with clk_out held.
//               Optional macro CLK_FREQ_DIVIDER_TICK_EN adds a one-cycle
//               tick output marking each rising edge of clk_out.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module clk_freq_divider
    import clk_freq_divider_pkg::*;
#(
    parameter int WIDTH = C_DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] div,
`ifdef CLK_FREQ_DIVIDER_TICK_EN
    output logic             tick,
`endif
    output logic             clk_out
);

    logic [WIDTH-1:0] r_cnt;
    logic             r_out;
    logic             w_halt;
    logic [WIDTH-1:0] w_div_m1;
    logic             w_terminal;

    // div is compared live, so a shrinking divisor ends the half-period at once
    assign w_halt     = (div == '0);
    assign w_div_m1   = div - WIDTH'(1);
    assign w_terminal = !w_halt && (r_cnt >= w_div_m1);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
            r_out <= 1'b0;
        end else if (w_halt) begin
            r_cnt <= '0;
        end else if (w_terminal) begin
            r_cnt <= '0;
            r_out <= ~r_out;
        end else begin
            r_cnt <= r_cnt + WIDTH'(1);
        end
    end

    assign clk_out = r_out;

`ifdef CLK_FREQ_DIVIDER_TICK_EN
    logic r_tick;

    // Registered alongside r_out so it coincides with the cycle clk_out reads 1 first
    always_ff @(posedge clk) begin
        if (rst) begin
            r_tick <= 1'b0;
        end else begin
            r_tick <= w_terminal && !r_out;
        end
    end

    assign tick = r_tick;
`endif

endmodule : clk_freq_divider

`default_nettype wire

// File: tb/tb_clk_freq_divider.sv
// ============================================================================
// Module      : tb_clk_freq_divider
// Description : Scoreboard bench for clk_freq_divider; directed scenarios
//               followed by randomized divisor and reset activity.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_clk_freq_divider;

    localparam int WIDTH = 4;

    logic             clk;
    logic             rst;
    logic [WIDTH-1:0] div;
    logic             clk_out;
`ifdef CLK_FREQ_DIVIDER_TICK_EN
    logic             tick;
`endif

    clk_freq_divider #(.WIDTH(WIDTH)) dut (
        .clk     (clk),
        .rst     (rst),
        .div     (div),
`ifdef CLK_FREQ_DIVIDER_TICK_EN
        .tick    (tick),
`endif
        .clk_out (clk_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic lvl;
        logic tck;
    } exp_t;

    exp_t exp_q[$];
    int   vectors   = 0;
    int   miscmp    = 0;
    int   cycle     = 0;

    // Reference: count clocks elapsed in the current half-period and flip the
    // level once that count reaches the divisor seen on this edge.
    int   m_elapsed = 0;
    logic m_lvl     = 1'b0;
    logic m_tick    = 1'b0;

    always @(posedge clk) begin
        exp_t e;
        if (rst) begin
            m_lvl     = 1'b0;
            m_elapsed = 0;
            m_tick    = 1'b0;
        end else if (div == 0) begin
            m_elapsed = 0;
            m_tick    = 1'b0;
        end else begin
            m_elapsed = m_elapsed + 1;
            m_tick    = 1'b0;
            if (m_elapsed >= int'(div)) begin
                m_lvl     = !m_lvl;
                m_elapsed = 0;
                m_tick    = m_lvl;
            end
        end
        e.lvl = m_lvl;
        e.tck = m_tick;
        exp_q.push_back(e);
    end

    always @(posedge clk) begin
        exp_t e;
        #1;
        cycle = cycle + 1;
        if (exp_q.size() == 0) begin
            vectors = vectors + 1;
            miscmp  = miscmp + 1;
            $display("FAIL scoreboard_empty cycle %0d: no expected entry", cycle);
        end else begin
            e = exp_q.pop_front();
            vectors = vectors + 1;
            if (clk_out !== e.lvl) begin
                miscmp = miscmp + 1;
                $display("FAIL clk_out cycle %0d div=%0d rst=%b: got %b expected %b",
                         cycle, div, rst, clk_out, e.lvl);
            end
`ifdef CLK_FREQ_DIVIDER_TICK_EN
            vectors = vectors + 1;
            if (tick !== e.tck) begin
                miscmp = miscmp + 1;
                $display("FAIL tick cycle %0d div=%0d: got %b expected %b",
                         cycle, div, tick, e.tck);
            end
`endif
        end
    end

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1;
        div = '0;
        step(2);

        // div=2: 0,0,1,1,... then div=1 and div=5
        rst = 1'b0; div = 4'd2; step(12);
        div = 4'd1; step(8);
        div = 4'd5; step(30);

        // Halt while high, then resume with div=3
        for (int i = 0; i < 20 && !m_lvl; i++) step(1);
        div = 4'd0; step(10);
        div = 4'd3; step(8);

        // Mid-period shrink 8 -> 2 with five clocks elapsed
        rst = 1'b1; step(1);
        rst = 1'b0; div = 4'd8; step(5);
        div = 4'd2; step(10);

        // Reset during the high phase with div=4
        div = 4'd4;
        for (int i = 0; i < 20 && !m_lvl; i++) step(1);
        step(2);
        rst = 1'b1; step(1);
        rst = 1'b0; step(12);

        // Largest divisor
        div = 4'd15; step(64);

        // Randomized divisor changes, halts and resets
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 15) == 0) begin
                if ($urandom_range(0, 7) == 0) div = '0;
                else div = WIDTH'($urandom_range(1, 15));
            end
            rst = ($urandom_range(0, 63) == 0);
            step(1);
        end
        rst = 1'b0;
        step(2);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscmp);
        $finish;
    end

endmodule : tb_clk_freq_divider

`default_nettype wire
